vcve2_vrf_port_arbiter: RTL and testbench

- Shares one OBI-style data memory port between NUM_REQ vcve2_vrf_interface requesters, such as the staggered VRF instances inside the VRF wrapper.
- It replaces the static port-select mux with two mechanisms:
  - round-robin request arbitration;
  - an in-order outstanding-ID FIFO that routes each rvalid/rdata/err response back to the requester that issued it.
- Sits between the VRF interface instances and one top-level data port.

---
 rtl/vcve2_pkg.sv | 10 +
 rtl/vcve2_vrf_arb_id_fifo.sv | 59 +++++
 rtl/vcve2_vrf_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_vcve2_vrf_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vcve2_pkg.sv
// Shared definitions for the vcve2 VRF data-port arbitration slice.
//   VRF_ARB_MAX_REQ : upper bound on the requester count the arbiter supports
//   vrf_arb_id_t    : requester ID carried through lock state and the ID FIFO
package vcve2_pkg;

    localparam int VRF_ARB_MAX_REQ = 4;

    typedef logic [1:0] vrf_arb_id_t;

endpackage

// File: rtl/vcve2_vrf_arb_id_fifo.sv
// In-order FIFO of requester IDs for granted transactions still awaiting rvalid.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push, push_id : enqueue an ID (ignored when full)
//   pop           : dequeue the head (ignored when empty)
//   full, empty   : occupancy flags
//   head          : oldest ID
//   count         : current occupancy, 0..DEPTH
module vcve2_vrf_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2,
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] push_id,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic [CNTW-1:0]  count
);

    // A single-entry FIFO still needs a 1-bit pointer to keep widths legal.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/vcve2_vrf_port_arbiter.sv
// Shares one OBI-style data port between NUM_REQ VRF interface requesters.
// Round-robin arbitration with a stall lock (a requester that has been
// selected but not granted keeps the port), plus an in-order ID FIFO that
// steers each rvalid/err back to the requester that issued the transaction.
//
// Build option: define VCVE2_VRF_ARB_FIXED_PRIO_EN to replace round-robin
// with fixed priority (lowest index wins); lock and FIFO behave the same.
//
// Ports:
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   req_*                 : per-requester OBI side (be/wdata packed by index)
//   req_rdata_o           : read data broadcast, qualify with req_rvalid_o
//   data_*                : shared memory port
//   busy_o                : at least one transaction outstanding
//   spurious_rvalid_o     : sticky, rvalid seen with nothing outstanding
module vcve2_vrf_port_arbiter
    import vcve2_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_req_i,
    output logic [NUM_REQ-1:0]      req_gnt_o,
    output logic [NUM_REQ-1:0]      req_rvalid_o,
    output logic [NUM_REQ-1:0]      req_err_o,
    input  logic [NUM_REQ-1:0]      req_we_i,
    input  logic [NUM_REQ*4-1:0]    req_be_i,
    input  logic [NUM_REQ*32-1:0]   req_wdata_i,
    output logic [31:0]             req_rdata_o,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic                    data_err_i,
    output logic                    data_we_o,
    output logic [3:0]              data_be_o,
    output logic [31:0]             data_wdata_o,
    input  logic [31:0]             data_rdata_i,
    output logic                    busy_o,
    output logic                    spurious_rvalid_o
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);

    if (NUM_REQ < 2 || NUM_REQ > VRF_ARB_MAX_REQ || IDW > $bits(vrf_arb_id_t)
        || MAX_OUTSTANDING < 1) begin : g_param_check
        $error("vcve2_vrf_port_arbiter: unsupported NUM_REQ/MAX_OUTSTANDING");
    end

    logic              lock_q;
    vrf_arb_id_t       lock_id_q;
    vrf_arb_id_t       search_start;
    vrf_arb_id_t       winner;
    logic              winner_req;
    logic              active;
    logic              fire;
    logic              pop;
    logic [NUM_REQ-1:0] rot;

    logic              fifo_full, fifo_empty;
    vrf_arb_id_t       fifo_head;
    logic [CNTW-1:0]   fifo_count;

`ifdef VCVE2_VRF_ARB_FIXED_PRIO_EN
    assign search_start = '0;
`else
    vrf_arb_id_t rr_ptr;

    assign search_start = rr_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   rr_ptr <= '0;
        else if (fire) rr_ptr <= (winner == vrf_arb_id_t'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
`endif

    // Rotate requests so bit 0 is the search start; first set bit wins.
    assign rot = NUM_REQ'({req_req_i, req_req_i} >> search_start);

    always_comb begin
        winner = '0;
        if (lock_q) begin
            winner = lock_id_q;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (rot[k]) winner = vrf_arb_id_t'((int'(search_start) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        winner_req = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner == vrf_arb_id_t'(j)) winner_req = req_req_i[j];
        end
    end

    // Gate with reset so nothing leaves the block while rst_ni is low,
    // even if a requester is already driving req.
    assign active     = rst_ni && winner_req;
    assign data_req_o = active && !fifo_full;
    assign fire       = data_req_o && data_gnt_i;
    assign pop        = data_rvalid_i && !fifo_empty;

    always_comb begin
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_wdata_o = '0;
        req_gnt_o    = '0;
        req_rvalid_o = '0;
        req_err_o    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (active && winner == vrf_arb_id_t'(j)) begin
                data_we_o    = req_we_i[j];
                data_be_o    = req_be_i[4*j +: 4];
                data_wdata_o = req_wdata_i[32*j +: 32];
            end
            req_gnt_o[j]    = fire && (winner == vrf_arb_id_t'(j));
            req_rvalid_o[j] = pop && (fifo_head == vrf_arb_id_t'(j));
            req_err_o[j]    = pop && data_err_i && (fifo_head == vrf_arb_id_t'(j));
        end
    end

    assign req_rdata_o = rst_ni ? data_rdata_i : '0;
    assign busy_o      = (fifo_count != '0);

    // Any selected-but-ungranted requester keeps the port, including when
    // issue is held off by a full FIFO, so it is served first after drain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q            <= 1'b0;
            lock_id_q         <= '0;
            spurious_rvalid_o <= 1'b0;
        end else begin
            lock_q    <= active && !fire;
            lock_id_q <= winner;
            if (data_rvalid_i && fifo_empty) spurious_rvalid_o <= 1'b1;
        end
    end

    vcve2_vrf_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH ($bits(vrf_arb_id_t))
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (fire),
        .push_id (winner),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_vcve2_vrf_port_arbiter.sv
// Self-checking bench for vcve2_vrf_port_arbiter: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_vcve2_vrf_port_arbiter;

    localparam int N  = 3;
    localparam int MO = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]    req, we;
    logic [4*N-1:0]  be;
    logic [32*N-1:0] wdata;
    logic            gnt, rvalid, err;
    logic [31:0]     rdata;

    logic [N-1:0] gnt_o, rv_o, err_o;
    logic [31:0]  rdata_o, dwd;
    logic         dreq, dwe, busy, spur;
    logic [3:0]   dbe;

    vcve2_vrf_port_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_req_i(req), .req_gnt_o(gnt_o), .req_rvalid_o(rv_o), .req_err_o(err_o),
        .req_we_i(we), .req_be_i(be), .req_wdata_i(wdata), .req_rdata_o(rdata_o),
        .data_req_o(dreq), .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_err_i(err),
        .data_we_o(dwe), .data_be_o(dbe), .data_wdata_o(dwd), .data_rdata_i(rdata),
        .busy_o(busy), .spurious_rvalid_o(spur)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // requester environment: each holds its payload until granted
    bit          pend [N];
    logic        r_we [N];
    logic [3:0]  r_be [N];
    logic [31:0] r_wd [N];

    task automatic new_req(input int i);
        pend[i] = 1'b1;
        r_we[i] = 1'($urandom_range(0, 1));
        r_be[i] = 4'($urandom);
        r_wd[i] = $urandom;
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req[i]          = pend[i];
            we[i]           = r_we[i];
            be[4*i +: 4]    = r_be[i];
            wdata[32*i +: 32] = r_wd[i];
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        pack();
    endtask

    // reference model
    bit m_lock;
    int m_lock_id;
    int m_rr;
    int m_q[$];
    bit m_spur;
    int mem_cnt;

    logic [N-1:0] o_gnt, o_rv, o_err;
    logic [3:0]   o_be;
    logic [31:0]  o_wd, o_rd;
    logic         o_dreq, o_busy, o_spur;

    task automatic model_reset();
        m_lock = 0; m_lock_id = 0; m_rr = 0; m_spur = 0;
        m_q.delete();
    endtask

    // Inputs are set by the caller at posedge+1; checks happen at negedge.
    task automatic run_cycle();
        int w, qn;
        bit wv, e_dreq, e_pop, e_we;
        logic [N-1:0] e_gnt, e_rv, e_err;
        logic [3:0]   e_be;
        logic [31:0]  e_wd;
        qn = m_q.size();
        w  = -1;
        if (m_lock) w = m_lock_id;
        else for (int k = 0; k < N; k++) if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
        wv = 0;
        if (w >= 0) wv = req[w];
        e_dreq = wv && (qn < MO);
        e_gnt = '0;
        if (e_dreq && gnt) e_gnt[w] = 1'b1;
        e_we = 0; e_be = '0; e_wd = '0;
        if (wv) begin
            e_we = we[w]; e_be = be[4*w +: 4]; e_wd = wdata[32*w +: 32];
        end
        e_pop = rvalid && (qn > 0);
        e_rv = '0; e_err = '0;
        if (e_pop) begin
            e_rv[m_q[0]]  = 1'b1;
            e_err[m_q[0]] = err;
        end

        @(negedge clk);
        o_gnt = gnt_o; o_rv = rv_o; o_err = err_o; o_be = dbe; o_wd = dwd;
        o_rd = rdata_o; o_dreq = dreq; o_busy = busy; o_spur = spur;
        chk("data_req", o_dreq, e_dreq);
        chk("req_gnt", o_gnt, e_gnt);
        chk("data_we", dwe, e_we);
        chk("data_be", o_be, e_be);
        chk("data_wdata", o_wd, e_wd);
        chk("req_rvalid", o_rv, e_rv);
        chk("req_err", o_err, e_err);
        chk("busy", o_busy, qn > 0);
        chk("spurious", o_spur, m_spur);
        if (e_pop) chk("req_rdata", o_rd, rdata);

        if (rvalid && qn == 0) m_spur = 1;
        if (e_pop) void'(m_q.pop_front());
        if (e_dreq && gnt) m_q.push_back(w);
        m_lock    = wv && !(e_dreq && gnt);
        m_lock_id = (w < 0) ? 0 : w;
`ifndef VCVE2_VRF_ARB_FIXED_PRIO_EN
        if (e_dreq && gnt) m_rr = (w + 1) % N;
`endif
        if (dreq && gnt) mem_cnt++;
        if (rvalid && mem_cnt > 0) mem_cnt--;
        for (int i = 0; i < N; i++) if (gnt_o[i]) pend[i] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        clear_reqs();
        gnt = 0; err = 0;
        guard = 0;
        while (mem_cnt > 0 && guard < 20) begin
            rvalid = 1; rdata = $urandom;
            run_cycle();
            guard++;
        end
        rvalid = 0;
        chk("drain_done", 64'(mem_cnt), 0);
    endtask

    logic [N-1:0] exp_rr [6];
    logic [3:0]   be1;
    logic [31:0]  wd1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
`ifdef VCVE2_VRF_ARB_FIXED_PRIO_EN
        for (int s = 0; s < 6; s++) exp_rr[s] = 3'b001;
`else
        exp_rr[0] = 3'b001; exp_rr[1] = 3'b010; exp_rr[2] = 3'b100;
        exp_rr[3] = 3'b001; exp_rr[4] = 3'b010; exp_rr[5] = 3'b100;
`endif
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; r_we[i] = 0; r_be[i] = '0; r_wd[i] = '0;
        end
        pack();
        gnt = 0; rvalid = 0; err = 0; rdata = '0;
        mem_cnt = 0;
        model_reset();
        rst_n = 0;

        // reset state
        #2;
        chk("rst_data_req", dreq, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rvalid", rv_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_spurious", spur, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;

        // round-robin, no contention, rvalid one cycle after each grant
        for (int i = 0; i < N; i++) new_req(i);
        pack();
        gnt = 1;
        for (int s = 0; s < 6; s++) begin
            rvalid = (mem_cnt > 0); rdata = $urandom; err = 0;
            run_cycle();
            chk("rr_order", o_gnt, exp_rr[s]);
            if (s > 0) chk("rr_rvalid_route", o_rv, exp_rr[s-1]);
            for (int i = 0; i < N; i++) if (!pend[i]) new_req(i);
            pack();
        end
        drain();

        // stall lock: requester 1 held while requester 0 joins
        clear_reqs();
        new_req(1); pack();
        be1 = r_be[1]; wd1 = r_wd[1];
        gnt = 0; rvalid = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin new_req(0); pack(); end
            run_cycle();
            chk("stall_be", o_be, be1);
            chk("stall_wdata", o_wd, wd1);
        end
        gnt = 1;
        run_cycle();
        chk("stall_gnt", o_gnt, 3'b010);
        chk("stall_wdata_gnt", o_wd, wd1);
        pack();
        run_cycle();
        chk("after_stall_gnt", o_gnt, 3'b001);
        drain();

        // outstanding limit
        new_req(0); pack();
        gnt = 1; rvalid = 0;
        for (int c = 0; c < 2; c++) begin
            run_cycle();
            new_req(0); pack();
        end
        run_cycle();
        chk("limit_req", o_dreq, 0);
        chk("limit_busy", o_busy, 1);
        rvalid = 1; rdata = $urandom;
        run_cycle();
        chk("limit_req_with_rvalid", o_dreq, 0);
        rvalid = 0;
        run_cycle();
        chk("limit_reopen", o_dreq, 1);
        drain();

        // error routing
        new_req(2); r_we[2] = 0; pack();
        gnt = 1;
        run_cycle();
        chk("err_issue_gnt", o_gnt, 3'b100);
        clear_reqs();
        gnt = 0; rvalid = 1; err = 1; rdata = 32'hDEADBEEF;
        run_cycle();
        chk("err_rvalid", o_rv, 3'b100);
        chk("err_err", o_err, 3'b100);
        chk("err_rdata", o_rd, 32'hDEADBEEF);
        rvalid = 0; err = 0;

        // spurious response, then asynchronous reset mid-operation
        rvalid = 1; rdata = $urandom;
        run_cycle();
        chk("spur_rvalid", o_rv, 0);
        rvalid = 0;
        run_cycle();
        chk("spur_flag", o_spur, 1);
        new_req(0); pack(); gnt = 1;
        run_cycle();
        new_req(1); pack(); gnt = 0;
        run_cycle();
        #1 rst_n = 0;
        #1;
        chk("arst_spurious", spur, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data_req", dreq, 0);
        model_reset();
        clear_reqs();
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        rvalid = 1; rdata = $urandom;
        run_cycle();
        chk("stale_rvalid", o_rv, 0);
        rvalid = 0;
        run_cycle();
        chk("stale_spur", o_spur, 1);
        new_req(0); new_req(1); pack(); gnt = 1;
        run_cycle();
        chk("post_rst_gnt", o_gnt, 3'b001);
        drain();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 2) == 0) new_req(i);
            pack();
            gnt    = ($urandom_range(0, 3) != 0);
            rvalid = (mem_cnt > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
            err    = ($urandom_range(0, 5) == 0);
            rdata  = $urandom;
            run_cycle();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
